// File: rtl/lsu_pkg.sv
// Load/store unit shared definitions.
// Access encodings, FSM states, lane masks and legality check.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_LO   = 4'b0011;
  localparam logic [3:0] BE_HI   = 4'b1100;
  localparam logic [3:0] BE_ALL  = 4'b1111;

  localparam int DEF_TIMEOUT = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE
  } lsu_state_t;

  function automatic logic access_legal(
    input logic       rd,
    input logic       wr,
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic ok;
    ok = 1'b0;
    if (rd ^ wr) begin
      case (f3)
        F3_B:    ok = 1'b1;
        F3_BU:   ok = rd;
        F3_H:    ok = ~off[0];
        F3_HU:   ok = rd & ~off[0];
        F3_W:    ok = (off == 2'b00);
        default: ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for the load/store unit.
// Store replication and byte enables, load lane pick and extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        we_i,
  input  logic [2:0]  st_f3_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  input  logic [2:0]  ld_f3_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] rdata_o
);

  logic [31:0] shifted;
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    be_o    = BE_NONE;
    wdata_o = wdata_i;
    if (we_i) begin
      unique case (1'b1)
        st_f3_i == F3_B: begin
          be_o    = 4'b0001 << st_off_i;
          wdata_o = {4{wdata_i[7:0]}};
        end
        st_f3_i == F3_H: begin
          be_o    = st_off_i[1] ? BE_HI : BE_LO;
          wdata_o = {2{wdata_i[15:0]}};
        end
        default: be_o = BE_ALL;
      endcase
    end
  end

  assign shifted = rdata_i >> {ld_off_i, 3'b000};
  assign b       = shifted[7:0];
  assign h       = ld_off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    rdata_o = rdata_i;
    unique case (1'b1)
      ld_f3_i == F3_B:  rdata_o = {{24{b[7]}}, b};
      ld_f3_i == F3_BU: rdata_o = {24'b0, b};
      ld_f3_i == F3_H:  rdata_o = {{16{h[15]}}, h};
      ld_f3_i == F3_HU: rdata_o = {16'b0, h};
      default:          rdata_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: one outstanding word access,
// stalls the pipeline until ack, faults on illegal or timed-out access.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int N       = 32,
  parameter int M       = 32,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [2:0]   funct3,
  input  logic [N-1:0] adr,
  input  logic [M-1:0] wdata,
  output logic [M-1:0] rdata,
  output logic         stall,
  output logic         fault,
  output logic         mem_req,
  output logic         mem_we,
  output logic [N-1:0] mem_adr,
  output logic [3:0]   mem_be,
  output logic [M-1:0] mem_wdata,
  input  logic [M-1:0] mem_rdata,
  input  logic         mem_ack
);

  localparam int CW = $clog2(TIMEOUT + 1);

  lsu_state_t  state_q;
  logic        req_q;
  logic        we_q;
  logic        fault_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [N-1:0] adr_q;
  logic [3:0]  be_q;
  logic [M-1:0] wdata_q;
  logic [M-1:0] rdata_q;
  logic [CW-1:0] cnt_q;

  logic        idle;
  logic        legal;
  logic        start;
  logic [3:0]  st_be;
  logic [M-1:0] st_wdata;
  logic [M-1:0] ld_data;

  assign idle  = (state_q == S_IDLE);
  assign legal = access_legal(mem_read, mem_write, funct3, adr[1:0]);
  // A timeout fault cycle lets the pipeline advance before retrying.
  assign start = idle & legal & ~fault_q;

  assign stall = reset_n & (start | (state_q == S_REQ));
  assign fault = reset_n &
                 (fault_q | (idle & (mem_read | mem_write) & ~legal));

  lsu_align u_align (
    .we_i     (mem_write),
    .st_f3_i  (funct3),
    .st_off_i (adr[1:0]),
    .wdata_i  (wdata),
    .be_o     (st_be),
    .wdata_o  (st_wdata),
    .ld_f3_i  (f3_q),
    .ld_off_i (off_q),
    .rdata_i  (mem_rdata),
    .rdata_o  (ld_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      fault_q <= 1'b0;
      f3_q    <= 3'b0;
      off_q   <= 2'b0;
      adr_q   <= '0;
      be_q    <= BE_NONE;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      fault_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_REQ;
            req_q   <= 1'b1;
            we_q    <= mem_write;
            f3_q    <= funct3;
            off_q   <= adr[1:0];
            adr_q   <= adr >> 2;
            be_q    <= st_be;
            wdata_q <= st_wdata;
            cnt_q   <= '0;
          end
        end
        S_REQ: begin
          if (mem_ack) begin
            state_q <= S_DONE;
            req_q   <= 1'b0;
            if (!we_q) rdata_q <= ld_data;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            fault_q <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_adr   = adr_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;
  assign rdata     = rdata_q;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter N, default 32, byte-address width.
REQ-002 Parameter M, default 32, data width; only 32 is supported.
REQ-003 Parameter TIMEOUT, default 16, maximum cycles to wait for mem_ack.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 mem_read  in  1  pipeline MEM stage requests a load.
REQ-007 mem_write  in  1  pipeline MEM stage requests a store.
REQ-008 funct3  in  3  access type: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; stores use 000 sb, 001 sh, 010 sw.
REQ-009 adr  in  N  byte address.
REQ-010 wdata  in  M  store data, right-aligned.
REQ-011 rdata  out  M  load result, extended, valid while state is DONE.
REQ-012 stall  out  1  freezes the pipeline while an access is in flight.
REQ-013 fault  out  1  one-cycle pulse for a misaligned, illegal or timed-out access.
REQ-014 mem_req  out  1  request to data memory; held high until acknowledged.
REQ-015 mem_we  out  1  write request; valid while mem_req is high.
REQ-016 mem_adr  out  N  word index, equal to adr >> 2.
REQ-017 mem_be  out  4  byte-lane write enables.
REQ-018 mem_wdata  out  M  lane-aligned store data.
REQ-019 mem_rdata  in  M  full word returned by memory; sampled in the mem_ack cycle.
REQ-020 mem_ack  in  1  memory completes the request this cycle.

Function
REQ-021 FSM states: IDLE, REQ, DONE.
REQ-022 IDLE to REQ: (mem_read xor mem_write) and the access is legal; capture adr, funct3, we, mem_be and mem_wdata.
REQ-023 Illegal access: misaligned (lh/lhu/sh with adr[0]=1; lw/sw with adr[1:0]!=0), undefined funct3 (011, 110, 111; stores also 100, 101), or mem_read and mem_write both high.
REQ-024 Illegal access in IDLE: fault=1 that cycle, state stays IDLE, no mem_req, stall=0.
REQ-025 stall = (IDLE and a legal access is present) or state==REQ; stall is combinational.
REQ-026 REQ: mem_req=1 with stable captured outputs; on mem_ack, go to DONE and register the extended load data into rdata.
REQ-027 Timeout: REQ holds a cycle counter; if TIMEOUT cycles pass without mem_ack, go to IDLE, drop mem_req, pulse fault, and take stall low for that cycle.
REQ-028 DONE: stall=0, rdata valid; unconditionally return to IDLE next cycle.
REQ-029 Minimum latency is 3 cycles (IDLE, REQ with ack, DONE); each additional wait cycle adds one.
REQ-030 mem_ack in IDLE or DONE is ignored.
REQ-031 Input changes during REQ are ignored; captured values are used.
REQ-032 Byte-enables: sb gives 1<<adr[1:0]; sh gives 0011 or 1100 by adr[1]; sw gives 1111; loads give 0000.
REQ-033 mem_wdata: sb replicates wdata[7:0] to all lanes; sh replicates wdata[15:0] to both halves; sw passes wdata through.
REQ-034 Load extraction: select the lane by captured adr[1:0]; lb/lh sign-extend, lbu/lhu zero-extend, lw passes through.
REQ-035 Stores leave rdata unchanged.

Reset
REQ-036 reset_n low, at any time (including mid-REQ), immediately forces: state IDLE, mem_req=0, mem_we=0, mem_be=0, mem_adr=0, mem_wdata=0, rdata=0, fault=0, counter=0.
REQ-037 No access is resumed after reset; the pipeline reissues it.

Structure
REQ-038 Package lsu_pkg holds: funct3 encodings, the FSM state enum, byte-enable constants and the default TIMEOUT.
REQ-039 One sub-module, lsu_align, is purely combinational: store lane replication, byte-enable generation, load lane selection and extension.

Verification
REQ-040 lw at adr 0x08, memory acks in the first REQ cycle with 0x0000000A -> stall high 2 cycles, rdata=0x0000000A in DONE, fault=0.
REQ-041 lb at adr 0x03 with mem_rdata 0x80FFFFFF -> rdata=0xFFFFFF80; lbu at the same address -> 0x00000080.
REQ-042 sh at adr 0x06 with wdata 0x1234ABCD -> mem_be=1100, mem_wdata=0xABCDABCD, mem_adr=1, mem_we=1.
REQ-043 lw at adr 0x02 -> fault pulse 1 cycle, mem_req never rises, stall=0.
REQ-044 Load with mem_ack withheld, TIMEOUT=16 -> mem_req high exactly 16 cycles, then fault pulse and return to IDLE.
REQ-045 reset_n dropped during REQ with 3 wait cycles elapsed -> mem_req and stall low immediately; a late mem_ack after reset is ignored.
